// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
// Decode-stage hazard detection and operand-forwarding control for the
// 5-stage pipeline. It keeps a small shadow of the destination registers
// sitting in EX, MEM and WB. From that shadow it derives the operand-mux
// selects, the load-use stall/bubble and a saturating stall-cycle counter.
//
// Build option: define FORWARDING_EN to enable the bypass network.
// Without it, the selects stay at 0 and any RAW dependence on EX or MEM
// stalls decode. WB never causes a stall, because the register file writes
// in the first half of the cycle and is read in the second half.
module hazard_forward_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_wr,
  input  logic             id_is_load,
  input  logic             id_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  // One tracking slot per downstream stage. The valid bit already folds in
  // reg_wr and rd!=0, so R0 writers never look like producers.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } entry_t;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;

  entry_t ex_q, mem_q, wb_q;
  entry_t ex_d;

  logic a_ex, a_mem, a_wb;
  logic b_ex, b_mem, b_wb;
  logic haz_a, haz_b;
  logic [1:0] sel_a, sel_b;

  // A source depends on a slot only if it is really read, is not R0, and
  // the slot holds a live producer of that register.
  function automatic logic src_match(input logic used,
                                     input logic [REG_W-1:0] src,
                                     input entry_t e);
    return used && e.valid && (e.rd == src) && (src != '0);
  endfunction

  // Compare both decode sources against every tracked producer.
  always_comb begin
    a_ex  = src_match(id_rs1_used, id_rs1, ex_q);
    a_mem = src_match(id_rs1_used, id_rs1, mem_q);
    a_wb  = src_match(id_rs1_used, id_rs1, wb_q);
    b_ex  = src_match(id_rs2_used, id_rs2, ex_q);
    b_mem = src_match(id_rs2_used, id_rs2, mem_q);
    b_wb  = src_match(id_rs2_used, id_rs2, wb_q);
  end

`ifdef FORWARDING_EN
  // The load's is_load flag only matters while the load is in EX. Once it
  // reaches MEM its data can be bypassed, so the later copies go unread.
  logic unused_load_bits;
  assign unused_load_bits = ^{mem_q.is_load, wb_q.is_load};

  // Choose the youngest producer for each source. A load still in EX cannot
  // be bypassed yet, so that case raises a hazard and parks the select at 0.
  always_comb begin
    haz_a = a_ex && ex_q.is_load;
    haz_b = b_ex && ex_q.is_load;
    sel_a = SEL_RF;
    sel_b = SEL_RF;
    if (haz_a)      sel_a = SEL_RF;
    else if (a_ex)  sel_a = SEL_EX;
    else if (a_mem) sel_a = SEL_MEM;
    else if (a_wb)  sel_a = SEL_WB;
    if (haz_b)      sel_b = SEL_RF;
    else if (b_ex)  sel_b = SEL_EX;
    else if (b_mem) sel_b = SEL_MEM;
    else if (b_wb)  sel_b = SEL_WB;
  end
`else
  // Without a bypass path, the WB slot and the load flags carry no decision
  // weight. The register file resolves the WB case by itself.
  logic unused_nofwd_bits;
  assign unused_nofwd_bits = ^{wb_q, a_wb, b_wb, ex_q.is_load, mem_q.is_load};

  // Every dependence on EX or MEM must wait until the value reaches the
  // register file, whatever kind of instruction produced it.
  always_comb begin
    haz_a = a_ex || a_mem;
    haz_b = b_ex || b_mem;
    sel_a = SEL_RF;
    sel_b = SEL_RF;
  end
`endif

  assign fwd_a_sel = sel_a;
  assign fwd_b_sel = sel_b;

  // A taken branch kills the decode instruction anyway, so its hazard is moot.
  // Flush therefore wins over stall, and both feed the bubble.
  always_comb begin
    stall  = (haz_a || haz_b) && !id_flush;
    bubble = stall || id_flush;
  end

  // Build the EX slot for the instruction leaving decode. Stalled, flushed
  // or empty decode slots enter EX as an invalid entry.
  always_comb begin
    ex_d.valid   = id_valid && !stall && !id_flush && id_reg_wr && (id_rd != '0);
    ex_d.rd      = id_rd;
    ex_d.is_load = id_is_load;
  end

  // Shift the tracking pipeline and count stall cycles without wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl
// Directed scenarios plus randomized traffic. Everything is checked against
// a behavioural model: a list of the last three issued instructions, from
// youngest to oldest, together with a saturating stall count. Follows
// FORWARDING_EN the same way the design does.
module tb_hazard_forward_ctrl;

  localparam int REG_W   = 3;
  localparam int CNT_W   = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic             id_rs1_used, id_rs2_used, id_reg_wr, id_is_load, id_flush;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             stall, bubble;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: slot 0 = youngest (EX), 1 = MEM, 2 = WB
  bit             m_valid [3];
  bit [REG_W-1:0] m_rd    [3];
  bit             m_load  [3];
  int             m_cnt;
  bit             model_ready = 1'b0;
  bit             last_stall;
  int             sat_stalls;

  hazard_forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
    .id_flush(id_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Work out the select and hazard for one source from the instruction history.
  task automatic modelSource(input bit used, input bit [REG_W-1:0] src,
                             output bit [1:0] sel, output bit haz);
    sel = 2'd0;
    haz = 1'b0;
    if (used && src != 0) begin
`ifdef FORWARDING_EN
      for (int i = 2; i >= 0; i--)
        if (m_valid[i] && m_rd[i] == src) sel = 2'(i + 1);
      if (m_valid[0] && m_rd[0] == src && m_load[0]) begin
        haz = 1'b1;
        sel = 2'd0;
      end
`else
      for (int i = 0; i < 2; i++)
        if (m_valid[i] && m_rd[i] == src) haz = 1'b1;
`endif
    end
  endtask

  // Apply one cycle of decode inputs, check against the model, then advance the model.
  task automatic applyStimulus(input bit rst, input bit valid,
                               input bit [REG_W-1:0] rs1, input bit u1,
                               input bit [REG_W-1:0] rs2, input bit u2,
                               input bit [REG_W-1:0] rd, input bit wr,
                               input bit ld, input bit fl);
    bit [1:0] sa, sb;
    bit ha, hb, e_stall, e_bubble;
    @(posedge clk);
    #1;
    reset = rst; id_valid = valid; id_rs1 = rs1; id_rs1_used = u1;
    id_rs2 = rs2; id_rs2_used = u2; id_rd = rd; id_reg_wr = wr;
    id_is_load = ld; id_flush = fl;
    #2;
    modelSource(u1, rs1, sa, ha);
    modelSource(u2, rs2, sb, hb);
    e_stall  = (ha || hb) && !fl;
    e_bubble = e_stall || fl;
    if (model_ready) begin
      checkOutput("fwd_a_sel", 32'(fwd_a_sel), 32'(sa));
      checkOutput("fwd_b_sel", 32'(fwd_b_sel), 32'(sb));
      checkOutput("stall", 32'(stall), 32'(e_stall));
      checkOutput("bubble", 32'(bubble), 32'(e_bubble));
      checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end
    last_stall = e_stall;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 1'b0; m_rd[i] = '0; m_load[i] = 1'b0;
      end
      m_cnt = 0;
      model_ready = 1'b1;
    end else begin
      for (int i = 2; i > 0; i--) begin
        m_valid[i] = m_valid[i-1]; m_rd[i] = m_rd[i-1]; m_load[i] = m_load[i-1];
      end
      m_valid[0] = valid && !e_stall && !fl && wr && rd != 0;
      m_rd[0]    = rd;
      m_load[0]  = ld;
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic instr(input bit [REG_W-1:0] rs1, input bit u1,
                       input bit [REG_W-1:0] rs2, input bit u2,
                       input bit [REG_W-1:0] rd, input bit wr,
                       input bit ld, input bit fl);
    applyStimulus(1'b0, 1'b1, rs1, u1, rs2, u2, rd, wr, ld, fl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_reg_wr = 1'b0;
    id_is_load = 1'b0; id_flush = 1'b0;

    // Reset state: bubble follows flush, everything else is quiet
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 0, 0, 0, 1'b1);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_bubble", 32'(bubble), 32'd1);
    checkOutput("rst_sel_a", 32'(fwd_a_sel), 32'd0);
    checkOutput("rst_cnt", 32'(stall_cnt), 32'd0);
    idle(2);

`ifdef FORWARDING_EN
    // ALU chain R1: select walks 1, 2, 3, 0
    instr(0, 0, 0, 0, 3'd1, 1, 0, 0);
    instr(3'd1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("chain_ex_sel", 32'(fwd_a_sel), 32'd1);
    checkOutput("chain_ex_stall", 32'(stall), 32'd0);
    instr(0, 0, 3'd1, 1, 0, 0, 0, 0);
    checkOutput("chain_mem_sel", 32'(fwd_b_sel), 32'd2);
    instr(0, 0, 3'd1, 1, 0, 0, 0, 0);
    checkOutput("chain_wb_sel", 32'(fwd_b_sel), 32'd3);
    instr(0, 0, 3'd1, 1, 0, 0, 0, 0);
    checkOutput("chain_rf_sel", 32'(fwd_b_sel), 32'd0);
    idle(3);

    // Load-use on R3: one stall cycle, then forward from MEM
    instr(0, 0, 0, 0, 3'd3, 1, 1, 0);
    instr(3'd3, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("lu_stall", 32'(stall), 32'd1);
    checkOutput("lu_bubble", 32'(bubble), 32'd1);
    instr(3'd3, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("lu_sel_mem", 32'(fwd_a_sel), 32'd2);
    checkOutput("lu_no_stall", 32'(stall), 32'd0);
    checkOutput("lu_cnt", 32'(stall_cnt), 32'd1);
    idle(3);

    // Youngest producer wins when EX and MEM both write R2
    instr(0, 0, 0, 0, 3'd2, 1, 0, 0);
    instr(0, 0, 0, 0, 3'd2, 1, 0, 0);
    instr(3'd2, 1, 3'd2, 1, 0, 0, 0, 0);
    checkOutput("prio_sel_a", 32'(fwd_a_sel), 32'd1);
    checkOutput("prio_sel_b", 32'(fwd_b_sel), 32'd1);
    idle(3);

    // Flush beats a load-use hazard and leaves EX empty
    instr(0, 0, 0, 0, 3'd4, 1, 1, 0);
    instr(3'd4, 1, 0, 0, 3'd6, 1, 0, 1);
    checkOutput("flush_stall", 32'(stall), 32'd0);
    checkOutput("flush_bubble", 32'(bubble), 32'd1);
    instr(3'd4, 1, 3'd6, 1, 0, 0, 0, 0);
    checkOutput("flush_sel_mem", 32'(fwd_a_sel), 32'd2);
    checkOutput("flush_ex_empty", 32'(fwd_b_sel), 32'd0);
    idle(3);
`else
    // No bypass: ALU write R5 then read R5 stalls twice with selects at 0
    instr(0, 0, 0, 0, 3'd5, 1, 0, 0);
    instr(3'd5, 1, 3'd5, 1, 0, 0, 0, 0);
    checkOutput("nf_stall1", 32'(stall), 32'd1);
    checkOutput("nf_sel_a1", 32'(fwd_a_sel), 32'd0);
    instr(3'd5, 1, 3'd5, 1, 0, 0, 0, 0);
    checkOutput("nf_stall2", 32'(stall), 32'd1);
    instr(3'd5, 1, 3'd5, 1, 0, 0, 0, 0);
    checkOutput("nf_proceed", 32'(stall), 32'd0);
    checkOutput("nf_sel_b", 32'(fwd_b_sel), 32'd0);
    checkOutput("nf_cnt", 32'(stall_cnt), 32'd2);
    idle(3);
`endif

    // A load to R0 never creates a dependence
    instr(0, 0, 0, 0, 3'd0, 1, 1, 0);
    instr(3'd0, 1, 3'd0, 1, 0, 0, 0, 0);
    checkOutput("r0_stall", 32'(stall), 32'd0);
    checkOutput("r0_sel", 32'(fwd_a_sel), 32'd0);
    idle(3);

    // Reset during a load-use stall clears the pending hazard
    instr(0, 0, 0, 0, 3'd3, 1, 1, 0);
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid_was_stall", 32'(stall), 32'd1);
    instr(3'd3, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("rstmid_stall", 32'(stall), 32'd0);
    checkOutput("rstmid_sel", 32'(fwd_a_sel), 32'd0);
    checkOutput("rstmid_cnt", 32'(stall_cnt), 32'd0);
    idle(3);

    // Saturation: a self-dependent load keeps stalling, well beyond 2^CNT_W+3 times
    sat_stalls = 0;
    for (int i = 0; i < 2200; i++) begin
      instr(3'd3, 1, 0, 0, 3'd3, 1, 1, 0);
      if (last_stall) sat_stalls++;
    end
    checkOutput("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    idle(3);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 7) != 0,
                    REG_W'($urandom_range(0, 7)), 1'($urandom),
                    REG_W'($urandom_range(0, 7)), 1'($urandom),
                    REG_W'($urandom_range(0, 7)), 1'($urandom),
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0);
    end

    $display("[TB] saturation phase saw %0d stall cycles", sat_stalls);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
